// File: rtl/mul_partial_combine.sv
// rtl/mul_partial_combine.sv - two-stage reduction of 16x16 partial products to the low 32 bits of a 32x32 product
// Optional feature macro: MUL_COMBINE_PERF_CNT_EN adds the mul_count completed-multiply counter.
module mul_partial_combine #(
  parameter int DST_W   = 5,
  parameter int CROSS_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_en,
  input  logic             M_mul_valid,
  input  logic [DST_W-1:0] M_dst_regnum,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             A_flush,
  output logic [31:0]      W_mul_result,
  output logic             W_mul_valid,
  output logic [DST_W-1:0] W_mul_dst_regnum,
`ifdef MUL_COMBINE_PERF_CNT_EN
  output logic             mul_busy,
  output logic [31:0]      mul_count
`else
  output logic             mul_busy
`endif
);

  logic               A_valid;
  logic [31:0]        A_p1;
  logic [CROSS_W-1:0] A_cross;
  logic [DST_W-1:0]   A_dst;
  logic [CROSS_W-1:0] cross_sum;
  logic [31:0]        w_sum;
  logic               unused_cross_hi;

  // Cross terms land at bit 16, so only their low halves reach the 32-bit result.
  assign cross_sum       = M_mul_cell_p2[CROSS_W-1:0] + M_mul_cell_p3[CROSS_W-1:0];
  assign unused_cross_hi = ^{M_mul_cell_p2[31:CROSS_W], M_mul_cell_p3[31:CROSS_W]};
  assign w_sum           = A_p1 + {A_cross, {(32-CROSS_W){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A_valid <= 1'b0;
      A_p1    <= '0;
      A_cross <= '0;
      A_dst   <= '0;
    end else if (M_en) begin
      A_valid <= M_mul_valid & ~A_flush;
      A_p1    <= M_mul_cell_p1;
      A_cross <= cross_sum;
      A_dst   <= M_dst_regnum;
    end else if (A_flush) begin
      // A stalled op can still be cancelled; data stays, only the valid drops.
      A_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_mul_valid      <= 1'b0;
      W_mul_result     <= '0;
      W_mul_dst_regnum <= '0;
    end else if (M_en) begin
      W_mul_valid      <= A_valid & ~A_flush;
      W_mul_result     <= w_sum;
      W_mul_dst_regnum <= A_dst;
    end
  end

  assign mul_busy = A_valid | W_mul_valid;

`ifdef MUL_COMBINE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_count <= '0;
    end else if (M_en && A_valid && !A_flush) begin
      mul_count <= mul_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_partial_combine.sv
// tb/tb_mul_partial_combine.sv - directed self-checking bench for mul_partial_combine
module tb_mul_partial_combine;

  localparam int DST_W = 5;

  logic             clk;
  logic             reset;
  logic             M_en;
  logic             M_mul_valid;
  logic [DST_W-1:0] M_dst_regnum;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic             A_flush;
  logic [31:0]      W_mul_result;
  logic             W_mul_valid;
  logic [DST_W-1:0] W_mul_dst_regnum;
  logic             mul_busy;
`ifdef MUL_COMBINE_PERF_CNT_EN
  logic [31:0]      mul_count;
`endif

  int n_checks;
  int n_pass;

  mul_partial_combine #(.DST_W(DST_W), .CROSS_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .M_en             (M_en),
    .M_mul_valid      (M_mul_valid),
    .M_dst_regnum     (M_dst_regnum),
    .M_mul_cell_p1    (M_mul_cell_p1),
    .M_mul_cell_p2    (M_mul_cell_p2),
    .M_mul_cell_p3    (M_mul_cell_p3),
    .A_flush          (A_flush),
    .W_mul_result     (W_mul_result),
    .W_mul_valid      (W_mul_valid),
    .W_mul_dst_regnum (W_mul_dst_regnum),
`ifdef MUL_COMBINE_PERF_CNT_EN
    .mul_busy         (mul_busy),
    .mul_count        (mul_count)
`else
    .mul_busy         (mul_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DST_W-1:0] d,
                       input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    M_mul_valid   = v;
    M_dst_regnum  = d;
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_w(input string tag, input logic v, input logic [31:0] res, input logic [DST_W-1:0] d);
    chk({tag, "_valid"}, {31'b0, W_mul_valid}, {31'b0, v});
    chk({tag, "_result"}, W_mul_result, res);
    chk({tag, "_dst"}, {27'b0, W_mul_dst_regnum}, {27'b0, d});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    M_en     = 1'b1;
    A_flush  = 1'b0;
    idle();

    // Reset held with random live inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DST_W'($urandom), $urandom, $urandom, $urandom);
      step();
    end
    chk_w("reset", 1'b0, 32'h0, '0);
    chk("reset_busy", {31'b0, mul_busy}, 32'h0);
`ifdef MUL_COMBINE_PERF_CNT_EN
    chk("reset_cnt", mul_count, 32'h0);
`endif
    drive(1'b0, DST_W'($urandom), $urandom, $urandom, $urandom);
    reset = 1'b0;
    step();
    step();
    chk("post_reset_valid", {31'b0, W_mul_valid}, 32'h0);
    chk("post_reset_busy", {31'b0, mul_busy}, 32'h0);

    // Basic: 0x00010002 * 0x00030004
    drive(1'b1, 5'd5, 32'd8, 32'd6, 32'd4);
    step();
    idle();
    chk("basic_e1_valid", {31'b0, W_mul_valid}, 32'h0);
    chk("basic_e1_busy", {31'b0, mul_busy}, 32'h1);
    step();
    chk_w("basic", 1'b1, 32'h000A0008, 5'd5);

    // -1 * -1: low word 1
    drive(1'b1, 5'd7, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    step();
    idle();
    step();
    chk_w("wrap", 1'b1, 32'h00000001, 5'd7);

    // Cross-term carry out of bit 31 discarded
    drive(1'b1, 5'd9, 32'h00001234, 32'h00008000, 32'h00008000);
    step();
    idle();
    step();
    chk_w("cross_carry", 1'b1, 32'h00001234, 5'd9);

    // Back-to-back ops with a 3-cycle stall between stages
    drive(1'b1, 5'd1, 32'd8, 32'd0, 32'd0);
    step();
    drive(1'b1, 5'd2, 32'd8, 32'd6, 32'd4);
    step();
    idle();
    chk_w("b2b_first", 1'b1, 32'd8, 5'd1);
    M_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd31, $urandom, $urandom, $urandom);
      step();
      chk_w($sformatf("stall%0d", i), 1'b1, 32'd8, 5'd1);
    end
    M_en = 1'b1;
    idle();
    step();
    chk_w("b2b_second", 1'b1, 32'h000A0008, 5'd2);
    step();
    chk("drain_valid", {31'b0, W_mul_valid}, 32'h0);
    chk("drain_busy", {31'b0, mul_busy}, 32'h0);

    // Flush with M_en=1 kills A op and incoming op
    drive(1'b1, 5'd3, 32'h55, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd4, 32'h66, 32'h0, 32'h0);
    A_flush = 1'b1;
    step();
    A_flush = 1'b0;
    idle();
    chk("flush_en_wvalid", {31'b0, W_mul_valid}, 32'h0);
    chk("flush_en_busy", {31'b0, mul_busy}, 32'h0);
    step();
    chk("flush_en_incoming", {31'b0, W_mul_valid}, 32'h0);

    // Flush with M_en=0 clears A only; W holds its result
    drive(1'b1, 5'd4, 32'h11, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd6, 32'h22, 32'h0, 32'h0);
    step();
    idle();
    M_en    = 1'b0;
    A_flush = 1'b1;
    step();
    A_flush = 1'b0;
    chk_w("flush_stall", 1'b1, 32'h11, 5'd4);
    M_en = 1'b1;
    step();
    chk("flush_stall_killed", {31'b0, W_mul_valid}, 32'h0);
    chk("flush_stall_busy", {31'b0, mul_busy}, 32'h0);

    // Reset mid-operation drops in-flight ops asynchronously
    drive(1'b1, 5'd10, 32'h77, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd11, 32'h88, 32'h0, 32'h0);
    step();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'b0, mul_busy}, 32'h0);
    chk("async_reset_result", W_mul_result, 32'h0);
    idle();
    step();
    reset = 1'b0;
    step();
    chk("after_reset_valid", {31'b0, W_mul_valid}, 32'h0);

`ifdef MUL_COMBINE_PERF_CNT_EN
    // Counter: 4 ops, the second flushed while nothing is entering
    chk("cnt_start", mul_count, 32'h0);
    drive(1'b1, 5'd1, 32'h1, 32'h0, 32'h0); step();
    drive(1'b1, 5'd2, 32'h2, 32'h0, 32'h0); step();
    idle(); A_flush = 1'b1; step(); A_flush = 1'b0;
    drive(1'b1, 5'd3, 32'h3, 32'h0, 32'h0); step();
    drive(1'b1, 5'd4, 32'h4, 32'h0, 32'h0); step();
    idle(); step(); step();
    chk("cnt_three", mul_count, 32'd3);
    force dut.mul_count = 32'hFFFFFFFF;
    #1;
    release dut.mul_count;
    drive(1'b1, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF); step();
    idle(); step();
    chk("cnt_wrap", mul_count, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
